svm_decision: RTL and testbench
===============================

SVM_DECISION -- requirements
Module: svm_decision

Interface
REQ-001 Parameter DATA_SIZE, default 32: width of each signed dual coefficient (alpha).
REQ-002 Parameter ACCUM_SIZE, default 64: width of each signed kernel term arriving from the kernel stage.
REQ-003 Parameter NUM_SV, default 3: number of kernel terms per test instance.
REQ-004 Parameter SCORE_SIZE, default ACCUM_SIZE+DATA_SIZE+$clog2(NUM_SV)+1: width of the signed decision score.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low (asserted when 0).
REQ-007 in_valid  input  1  kernel term present on in_kernel this cycle; no backpressure toward the producer.
REQ-008 in_kernel  input  ACCUM_SIZE  signed kernel term; terms arrive in support-vector order 0..NUM_SV-1.
REQ-009 flush  input  1  abandons the partially accumulated instance.
REQ-010 alpha  input  NUM_SV x DATA_SIZE  signed dual coefficients, static while not idle.
REQ-011 bias  input  ACCUM_SIZE  signed bias, static while not idle.
REQ-012 out_valid  output  1  head of output queue holds a result.
REQ-013 out_ready  input  1  consumer accepts the head when out_valid && out_ready.
REQ-014 out_score  output  SCORE_SIZE  signed decision score.
REQ-015 out_label  output  1  1 when out_score >= 0, else 0.
REQ-016 overflow  output  1  sticky: a finished result was dropped because the queue was full.
REQ-017 busy  output  1  at least one term of the current instance has been accepted and not yet completed.

Function
REQ-018 The stage computes, per instance: score = bias + sum over i of alpha[i]*kernel_i, all signed and sign-extended to SCORE_SIZE, with no truncation or saturation.
REQ-019 Stage 1 registers product = in_kernel*alpha[sv_cnt] and the index, tagged with the valid and last flags (last when sv_cnt == NUM_SV-1).
REQ-020 sv_cnt increments on each accepted term and wraps from NUM_SV-1 to 0.
REQ-021 Stage 2 accumulates: on the first term it loads acc = bias + product; on later terms it sets acc = acc + product.
REQ-022 When the term in stage 2 carries last, the sum (acc + product) is pushed into the output queue, and acc is not needed afterwards.
REQ-023 Latency: the result is visible on out_valid 2 cycles after the clock edge that samples the last in_valid, provided the queue was empty.
REQ-024 Back-to-back instances with no idle cycles are supported at one term per cycle.
REQ-025 The FSM has two states. IDLE (sv_cnt == 0, no partial sum) moves to ACC on in_valid. ACC returns to IDLE after the last term is accepted, or on flush.
REQ-026 flush clears sv_cnt, the stage-1 valid flag and the partial acc; a term that arrives in the same cycle as flush is discarded.
REQ-027 flush does not clear the output queue, nor a completed result already written into it.
REQ-028 The output queue is a 2-entry FIFO, first in first out; out_score and out_label come from the head entry.
REQ-029 When the queue is full, a simultaneous pop and push succeeds.
REQ-030 When the queue is full with no pop, a push drops the new result and sets overflow.
REQ-031 out_label is computed at push time and stored alongside the score.
REQ-032 busy = (state == ACC) || stage-1 valid || stage-2 holds a non-last term.

Reset
REQ-033 While rst == 0 at a rising edge, state becomes IDLE, sv_cnt becomes 0, all pipeline valid flags become 0 and the queue becomes empty.
REQ-034 While rst == 0 at a rising edge, out_valid, out_score, out_label, overflow and busy are all 0.
REQ-035 A reset in the middle of an instance discards the partial sum; the next in_valid is treated as term 0.

Structure
REQ-036 DATA_SIZE, ACCUM_SIZE, NUM_SV, the SCORE_SIZE formula and the state enum (IDLE, ACC) belong in the shared svm_pkg, which is also used by the kernel stage.
REQ-037 The output queue is a separate sub-module, svm_result_fifo, parameterised by width and depth (depth 2 here).

Verification
REQ-038 Basic score: alpha={1,-2,3}, bias=-5, kernels 10,20,30 on consecutive cycles, out_ready=1 -> out_score=55, out_label=1, 2 cycles after the last term.
REQ-039 Negative score and back-to-back: with the same coefficients, feed 0,10,0 immediately after the REQ-038 instance -> second result -25, label 0, one cycle apart from or later than the first.
REQ-040 Backpressure: out_ready=0 for three instances (55, 15 via kernels 30,20,10, then -25) -> queue holds 55 and 15 and overflow=1; after releasing out_ready, pops yield 55 then 15 only.
REQ-041 Flush: feed 10,20, pulse flush together with a third term 99, then feed 30,20,10 -> the only result is 15.
REQ-042 Reset mid-instance: after kernels 10,20, drive rst=0 for one cycle, then feed 10,20,30 -> all outputs are 0 during reset and the only result is 55.
REQ-043 Width extremes: alpha all -2^31, kernels all -2^63, bias 0 -> out_score = 3*2^94, exactly, with no wrap, and out_label=1.

Source files
------------

// File: rtl/svm_pkg.sv
// svm_pkg: widths, score-width formula and FSM state shared by the SVM kernel and decision stages
package svm_pkg;
    localparam int DATA_SIZE = 32;
    localparam int ACCUM_SIZE = 64;
    localparam int NUM_SV = 3;
    localparam int SCORE_SIZE = ACCUM_SIZE + DATA_SIZE + $clog2(NUM_SV) + 1;
    typedef enum logic {IDLE, ACC} state_t;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/svm_decision_if.sv
// svm_decision_if: kernel-term input, coefficients and decision-result bundle
interface svm_decision_if #(
    parameter int DATA_SIZE = svm_pkg::DATA_SIZE,
    parameter int ACCUM_SIZE = svm_pkg::ACCUM_SIZE,
    parameter int NUM_SV = svm_pkg::NUM_SV,
    parameter int SCORE_SIZE = ACCUM_SIZE + DATA_SIZE + $clog2(NUM_SV) + 1
);
    logic in_valid;
    logic signed [ACCUM_SIZE-1:0] in_kernel;
    logic flush;
    logic [NUM_SV-1:0][DATA_SIZE-1:0] alpha;
    logic signed [ACCUM_SIZE-1:0] bias;
    logic out_valid;
    logic out_ready;
    logic signed [SCORE_SIZE-1:0] out_score;
    logic out_label;
    logic overflow;
    logic busy;
    modport master (
        output in_valid, in_kernel, flush, alpha, bias, out_ready,
        input out_valid, out_score, out_label, overflow, busy
    );
    modport slave (
        input in_valid, in_kernel, flush, alpha, bias, out_ready,
        output out_valid, out_score, out_label, overflow, busy
    );
endinterface

// File: rtl/svm_result_fifo.sv
// svm_result_fifo: small FIFO for finished results; a full queue still takes a push paired with a pop
module svm_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic do_push, do_pop;
    always_comb begin
        empty = cnt_q == '0;
        full = cnt_q == CW'(DEPTH);
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = din;
        rd_d = do_pop ? (rd_q == AW'(DEPTH - 1) ? '0 : rd_q + AW'(1)) : rd_q;
        wr_d = do_push ? (wr_q == AW'(DEPTH - 1) ? '0 : wr_q + AW'(1)) : wr_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        dout = mem_q[rd_q];
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_q <= '0;
            wr_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q <= rd_d;
            wr_q <= wr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/svm_decision.sv
// svm_decision: score = bias + sum(alpha[i]*kernel_i) over a multiply stage and an accumulate stage, into a 2-deep result queue
module svm_decision import svm_pkg::*; #(
    parameter int DATA_SIZE = svm_pkg::DATA_SIZE,
    parameter int ACCUM_SIZE = svm_pkg::ACCUM_SIZE,
    parameter int NUM_SV = svm_pkg::NUM_SV,
    parameter int SCORE_SIZE = ACCUM_SIZE + DATA_SIZE + $clog2(NUM_SV) + 1
) (
    input logic clk,
    input logic rst,
    svm_decision_if.slave io
);
    localparam int PW = ACCUM_SIZE + DATA_SIZE;
    localparam int CW = idx_w(NUM_SV);
    localparam logic [CW-1:0] LAST = CW'(NUM_SV - 1);
    state_t state_q, state_d;
    logic [CW-1:0] sv_cnt_q, sv_cnt_d;
    logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic [CW-1:0] s1_idx_q, s1_idx_d;
    logic signed [PW-1:0] s1_prod_q, s1_prod_d;
    logic s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    logic signed [SCORE_SIZE-1:0] acc_q, acc_d;
    logic overflow_q, overflow_d;
    logic accept, last_in, push, pop, full, empty;
    logic [SCORE_SIZE:0] head;
    always_comb begin
        accept = io.in_valid && !io.flush;
        last_in = sv_cnt_q == LAST;
        state_d = io.flush ? IDLE : accept ? (last_in ? IDLE : ACC) : state_q;
        sv_cnt_d = io.flush ? '0 : accept ? (last_in ? '0 : sv_cnt_q + CW'(1)) : sv_cnt_q;
        s1_valid_d = accept;
        s1_last_d = last_in;
        s1_idx_d = sv_cnt_q;
        s1_prod_d = PW'($signed(io.in_kernel)) * PW'($signed(io.alpha[sv_cnt_q]));
        // a flush kills only partial work; a completed last term still reaches the queue
        s2_valid_d = s1_valid_q && !(io.flush && !s1_last_q);
        s2_last_d = s1_last_q;
        acc_d = s1_valid_q ? (s1_idx_q == '0 ? SCORE_SIZE'($signed(io.bias)) : acc_q) + SCORE_SIZE'(s1_prod_q) : acc_q;
        push = s2_valid_q && s2_last_q;
        pop = !empty && io.out_ready;
        overflow_d = overflow_q || (push && full && !pop);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            sv_cnt_q <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sv_cnt_q <= sv_cnt_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            overflow_q <= overflow_d;
        end
    end
    always_ff @(posedge clk) begin
        s1_last_q <= s1_last_d;
        s1_idx_q <= s1_idx_d;
        s1_prod_q <= s1_prod_d;
        s2_last_q <= s2_last_d;
        acc_q <= acc_d;
    end
    svm_result_fifo #(.WIDTH(SCORE_SIZE + 1), .DEPTH(2)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .din({!acc_q[SCORE_SIZE-1], acc_q}),
        .pop(pop),
        .dout(head),
        .empty(empty),
        .full(full)
    );
    assign io.out_valid = !empty;
    assign io.out_score = head[SCORE_SIZE-1:0];
    assign io.out_label = head[SCORE_SIZE];
    assign io.overflow = overflow_q;
    assign io.busy = state_q == ACC || s1_valid_q || (s2_valid_q && !s2_last_q);
endmodule

// File: tb/tb_svm_decision.sv
// tb_svm_decision: directed and random instances scored by a formula model and a latency-aware queue scoreboard
module tb_svm_decision;
    import svm_pkg::*;
    localparam int SW = SCORE_SIZE;
    typedef logic signed [SW-1:0] score_t;
    typedef struct {score_t s; int at;} pend_t;
    logic clk = 0;
    logic rst = 0;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit rst_prev = 0;
    bit exp_ovf = 0;
    score_t expq[$];
    score_t got[$];
    pend_t pend[$];
    logic signed [ACCUM_SIZE-1:0] inst[$];
    logic signed [DATA_SIZE-1:0] al [NUM_SV];
    logic signed [ACCUM_SIZE-1:0] bs;
    svm_decision_if io();
    svm_decision dut(.clk(clk), .rst(rst), .io(io));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic signed [127:0] act, input logic signed [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    function automatic score_t model_score();
        score_t s = SW'(bs);
        for (int i = 0; i < NUM_SV; i++) s += SW'(al[i]) * SW'(inst[i]);
        return s;
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic apply();
        for (int i = 0; i < NUM_SV; i++) io.alpha[i] = al[i];
        io.bias = bs;
    endtask
    // result reaches the queue two edges after the edge that samples the last term
    task automatic term(input logic signed [ACCUM_SIZE-1:0] k, input bit fl = 1'b0);
        io.in_valid = 1;
        io.in_kernel = k;
        io.flush = fl;
        if (fl) inst.delete();
        else begin
            inst.push_back(k);
            if (inst.size() == NUM_SV) begin
                pend.push_back('{model_score(), cyc + 3});
                inst.delete();
            end
        end
        step();
        io.in_valid = 0;
        io.flush = 0;
    endtask
    task automatic drain(input string name);
        int n = 0;
        io.out_ready = 1;
        while ((pend.size() > 0 || expq.size() > 0 || io.out_valid) && n < 40) begin
            step();
            n++;
        end
        step();
        chk({name, " drain"}, n < 40, 1);
    endtask
    always @(posedge clk) begin
        cyc++;
        rst_prev = rst;
        if (!rst) begin
            expq.delete();
            pend.delete();
            exp_ovf = 0;
        end else begin
            if (expq.size() > 0 && io.out_ready) void'(expq.pop_front());
            while (pend.size() > 0 && pend[0].at <= cyc) begin
                if (expq.size() < 2) expq.push_back(pend[0].s);
                else exp_ovf = 1;
                void'(pend.pop_front());
            end
        end
    end
    always @(negedge clk) begin
        if (!rst_prev) begin
            chk("rst out_valid", io.out_valid, 0);
            chk("rst out_score", io.out_score, 0);
            chk("rst out_label", io.out_label, 0);
            chk("rst overflow", io.overflow, 0);
            chk("rst busy", io.busy, 0);
        end else begin
            chk("out_valid", io.out_valid, expq.size() > 0);
            if (io.out_valid && expq.size() > 0) begin
                chk("out_score", io.out_score, expq[0]);
                chk("out_label", io.out_label, expq[0] >= 0);
                if (io.out_ready) got.push_back(io.out_score);
            end
            chk("overflow", io.overflow, exp_ovf);
        end
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        score_t big;
        logic [63:0] kr;
        int r;
        io.in_valid = 0;
        io.in_kernel = 0;
        io.flush = 0;
        io.out_ready = 1;
        al = '{1, -2, 3};
        bs = -5;
        apply();
        repeat (3) step();
        rst = 1;
        step();
        chk("idle busy", io.busy, 0);
        got.delete();
        term(10); term(20); term(30); term(0); term(10); term(0);
        drain("basic");
        chk("basic count", got.size(), 2);
        if (got.size() == 2) begin
            chk("basic r0", got[0], 55);
            chk("basic r1", got[1], -25);
        end
        io.out_ready = 0;
        got.delete();
        term(10); term(20); term(30); term(30); term(20); term(10); term(0); term(10); term(0);
        repeat (4) step();
        chk("bp overflow", io.overflow, 1);
        chk("bp held", io.out_valid, 1);
        chk("bp head", io.out_score, 55);
        drain("bp");
        chk("bp count", got.size(), 2);
        if (got.size() == 2) begin
            chk("bp r0", got[0], 55);
            chk("bp r1", got[1], 15);
        end
        rst = 0;
        step();
        rst = 1;
        step();
        chk("ovf cleared", io.overflow, 0);
        got.delete();
        term(10); term(20);
        chk("flush busy", io.busy, 1);
        term(99, 1);
        term(30); term(20); term(10);
        drain("flush");
        chk("flush count", got.size(), 1);
        if (got.size() == 1) chk("flush r0", got[0], 15);
        chk("flush idle", io.busy, 0);
        got.delete();
        term(10); term(20);
        rst = 0;
        step();
        inst.delete();
        rst = 1;
        term(10); term(20); term(30);
        step();
        chk("lat early", io.out_valid, 0);
        step();
        chk("lat valid", io.out_valid, 1);
        chk("lat score", io.out_score, 55);
        drain("rstmid");
        chk("rstmid count", got.size(), 1);
        if (got.size() == 1) chk("rstmid r0", got[0], 55);
        al = '{32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000};
        bs = 0;
        apply();
        got.delete();
        big = 3;
        big = big << 94;
        repeat (3) term(64'sh8000_0000_0000_0000);
        drain("extreme");
        chk("extreme count", got.size(), 1);
        if (got.size() == 1) chk("extreme r0", got[0], big);
        repeat (12) begin
            for (int i = 0; i < NUM_SV; i++) al[i] = $urandom();
            bs = {$urandom(), $urandom()};
            apply();
            for (int j = 0; j < 40; j++) begin
                io.out_ready = $urandom_range(0, 3) != 0;
                r = $urandom_range(0, 9);
                kr = {$urandom(), $urandom()};
                if (r == 0) step();
                else term(kr, r == 1);
            end
            if (inst.size() > 0) term(0, 1);
            drain("random");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
